// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the mul_acc_nn multiply-accumulate unit.
package mul_pkg;

  // Control FSM states for the multi-cycle multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of shift-add iterations needed to consume a WIDTH-bit multiplier.
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // True when the digit size is legal and evenly divides the operand width.
  function automatic bit width_ok(input int width, input int digit);
    return (digit >= 1) ? ((width % digit) == 0) : 1'b0;
  endfunction

endpackage

// File: rtl/mul_digit.sv
// Combinational WIDTH x DIGIT partial-product generator.
module mul_digit
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       d,
  output logic [WIDTH+DIGIT-1:0] pp
);

  // A WIDTH-bit value times a DIGIT-bit value always fits in WIDTH+DIGIT bits.
  assign pp = {{DIGIT{1'b0}}, a} * {{WIDTH{1'b0}}, d};

endmodule

// File: rtl/mul_acc_nn.sv
// Multi-cycle radix-2^DIGIT shift-add multiply-accumulate:
// {carry, result} = ina * inb + (acc_en ? acc_in : 0), one digit per cycle.
module mul_acc_nn
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  input  logic               acc_en,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               busy,
  output logic               done,
  output logic               ready_n
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int ACCW = 2 * WIDTH + 1;
  localparam int SHW  = $clog2(ACCW);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("mul_acc_nn: WIDTH must be a positive multiple of DIGIT");
  end

  state_t                 state;
  state_t                 state_next;
  logic                   accept;
  logic                   last;
  logic [CNTW-1:0]        cnt;
  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [ACCW-1:0]        acc;
  logic [ACCW-1:0]        acc_sum;
  logic [WIDTH+DIGIT-1:0] pp;
  logic [SHW-1:0]         shamt;

  // The multiplier register shifts right every iteration, so the current digit is always its LSBs.
  mul_digit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_digit (
    .a  (a_reg),
    .d  (b_reg[DIGIT-1:0]),
    .pp (pp)
  );

  // Partial product lands at bit position cnt*DIGIT; the accumulator is wide enough never to overflow.
  assign shamt   = SHW'(cnt) * SHW'(DIGIT);
  assign acc_sum = acc + (ACCW'(pp) << shamt);

  // Next-state logic; accept marks an accepting edge, last marks the completion edge.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (cnt == CNTW'(NDIG - 1)) begin
          state_next = DONE;
          last       = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and registered status outputs; start during RUN never reaches here because accept is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      result  <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready_n <= 1'b1;
    end else begin
      done <= last;
      if (accept) begin
        a_reg   <= ina;
        b_reg   <= inb;
        acc     <= acc_en ? {1'b0, acc_in} : '0;
        cnt     <= '0;
        busy    <= 1'b1;
        ready_n <= 1'b1;
      end else if (state == RUN) begin
        acc   <= acc_sum;
        b_reg <= b_reg >> DIGIT;
        cnt   <= cnt + CNTW'(1);
        if (last) begin
          result  <= acc_sum[2*WIDTH-1:0];
          carry   <= acc_sum[2*WIDTH];
          busy    <= 1'b0;
          ready_n <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_acc_nn.sv
// Directed, table-driven bench for mul_acc_nn (64x64 radix-16 and 32x32 radix-2 instances).
module tb_mul_acc_nn;

  logic         clk;
  logic         rst;
  logic         start;
  logic [63:0]  ina;
  logic [63:0]  inb;
  logic         acc_en;
  logic [127:0] acc_in;
  logic [127:0] result;
  logic         carry;
  logic         busy;
  logic         done;
  logic         ready_n;

  logic         start32;
  logic [31:0]  ina32;
  logic [31:0]  inb32;
  logic         acc_en32;
  logic [63:0]  acc_in32;
  logic [63:0]  result32;
  logic         carry32;
  logic         busy32;
  logic         done32;
  logic         ready_n32;

  int n_cmp = 0;
  int n_err = 0;

  mul_acc_nn #(.WIDTH(64), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ina(ina), .inb(inb),
    .acc_en(acc_en), .acc_in(acc_in), .result(result), .carry(carry),
    .busy(busy), .done(done), .ready_n(ready_n)
  );

  mul_acc_nn #(.WIDTH(32), .DIGIT(1)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .ina(ina32), .inb(inb32),
    .acc_en(acc_en32), .acc_in(acc_in32), .result(result32), .carry(carry32),
    .busy(busy32), .done(done32), .ready_n(ready_n32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic         ae;
    logic [127:0] ai;
    logic [128:0] exp;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [128:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic ae, input logic [127:0] ai);
    return (129'(a) * 129'(b)) + (ae ? {1'b0, ai} : 129'd0);
  endfunction

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Accept one operation, scramble the inputs afterwards, wait (bounded) for done.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic ae,
                       input logic [127:0] ai, output int lat, output int busy_cnt);
    @(negedge clk);
    ina = a; inb = b; acc_en = ae; acc_in = ai; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ina = {$urandom, $urandom}; inb = {$urandom, $urandom};
    acc_en = ~ae; acc_in = {$urandom, $urandom, $urandom, $urandom};
    lat = 0; busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 200);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bc;
    int ndone;
    int at;
    int n0;
    int n1;
    int n2;
    logic [128:0] r;

    vecs[0] = '{64'd1, 64'd1, 1'b0, 128'd0, 129'd1};
    vecs[1] = '{64'h10, 64'h100, 1'b0, 128'd0, 129'h1000};
    vecs[2] = '{64'hed91f81fda13, 64'hd91ae301dedd, 1'b0, 128'd0,
                model(64'hed91f81fda13, 64'hd91ae301dedd, 1'b0, 128'd0)};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, {128{1'b1}},
                {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0000}};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, {128{1'b1}},
                {1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}};
    vecs[5] = '{64'd3, 64'd5, 1'b1, 128'd7, 129'd22};
    vecs[6] = '{64'd2, 64'd3, 1'b0, {128{1'b1}}, 129'd6};

    rst = 1'b1; start = 1'b0; ina = '0; inb = '0; acc_en = 1'b0; acc_in = '0;
    start32 = 1'b0; ina32 = '0; inb32 = '0; acc_en32 = 1'b0; acc_in32 = '0;

    // Reset state.
    @(posedge clk); #1;
    chk("reset result", {carry, result}, 129'd0);
    chk("reset flags busy/done/ready_n", {busy, done, ready_n}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors: value, latency, busy length, done pulse width.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].ae, vecs[i].ai, lat, bc);
      chk($sformatf("v%0d result", i), {carry, result}, vecs[i].exp);
      chk($sformatf("v%0d latency", i), 129'(lat), 129'd16);
      chk($sformatf("v%0d busy cycles", i), 129'(bc), 129'd16);
      chk($sformatf("v%0d busy/ready_n at done", i), {busy, ready_n}, {1'b0, 1'b0});
      @(posedge clk); #1;
      chk($sformatf("v%0d done one cycle", i), {done, ready_n}, {1'b0, 1'b0});
      chk($sformatf("v%0d result held", i), {carry, result}, vecs[i].exp);
    end

    // start pulsed mid-RUN with new operands is ignored.
    @(negedge clk);
    ina = 64'h1234_5678_9abc_def0; inb = 64'h0fed_cba9_8765_4321;
    acc_en = 1'b1; acc_in = 128'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; at = 0; r = '0;
    for (int e = 1; e <= 24; e++) begin
      @(negedge clk);
      if (e == 5) begin
        start = 1'b1; ina = 64'hdead_beef; inb = 64'hcafe_f00d; acc_en = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++; at = e; r = {carry, result};
      end
    end
    chk("midrun start done count", 129'(ndone), 129'd1);
    chk("midrun start done cycle", 129'(at), 129'd16);
    chk("midrun start result",
        r, model(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 1'b1, 128'h5555));

    // Reset 8 cycles into RUN.
    @(negedge clk);
    ina = 64'h77; inb = 64'h99; acc_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
    end
    chk("busy before reset", 129'(busy), 129'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async reset result", {carry, result}, 129'd0);
    chk("async reset flags busy/done/ready_n", {busy, done, ready_n}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("no done after reset", 129'(ndone), 129'd0);
    chk("idle flags after reset", {busy, ready_n}, {1'b0, 1'b1});
    do_op(64'hABCD, 64'h1234, 1'b0, 128'd0, lat, bc);
    chk("post-reset result", {carry, result}, 129'h0C374FA4);
    chk("post-reset latency", 129'(lat), 129'd16);

    // Back-to-back with start held high across three operations.
    @(negedge clk);
    ina = 64'h1111_2222_3333_4444; inb = 64'h5555_6666_7777_8888;
    acc_en = 1'b0; acc_in = '0; start = 1'b1;
    @(posedge clk); #1;
    ina = 64'hFFFF_0000_FFFF_0000; inb = 64'h0123_4567_89AB_CDEF;
    acc_en = 1'b1; acc_in = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    wait_done(n0);
    chk("b2b op0 latency", 129'(n0), 129'd16);
    chk("b2b op0 result", {carry, result},
        model(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 128'd0));
    @(posedge clk); #1;
    chk("b2b op1 accepted busy", {busy, done, ready_n}, {1'b1, 1'b0, 1'b1});
    ina = 64'd12345; inb = 64'd67890; acc_en = 1'b0; acc_in = '0;
    wait_done(n1);
    chk("b2b op1 done spacing", 129'(n1 + 1), 129'd17);
    chk("b2b op1 result", {carry, result},
        model(64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 1'b1,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n2);
    chk("b2b op2 done spacing", 129'(n2 + 1), 129'd17);
    chk("b2b op2 result", {carry, result}, 129'd838102050);

    // 32-bit, one bit per cycle instance.
    @(negedge clk);
    ina32 = 32'hf81fda13; inb32 = 32'he301dedd; acc_en32 = 1'b0; acc_in32 = '0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; ina32 = 32'h0; inb32 = 32'h0;
    lat = 0;
    while (!done32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w32 latency", 129'(lat), 129'd32);
    chk("w32 result", {carry32, result32},
        model(64'hf81fda13, 64'he301dedd, 1'b0, 128'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_acc_nn.md
# mul_acc_nn

Parametrised multi-cycle multiply-accumulate unit: computes `ina * inb (+ acc_in)` for WIDTH-bit unsigned operands using a radix-2^DIGIT shift-add datapath. It replaces the fixed 32x32 and 64x64 multipliers as the product engine for the RSA modular-exponentiation datapath. It adds three things the fixed multipliers lack:
- an explicit start/done handshake;
- an accumulate mode for multi-precision limb arithmetic;
- a carry-out bit.

## Interface
Parameters:
- `WIDTH`, 64: operand width in bits; must be a multiple of DIGIT.
- `DIGIT`, 4: multiplier bits consumed per cycle; must be ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new operation. Sampled only in IDLE or DONE.
- `ina`  in  WIDTH  multiplicand. Captured on the accepting edge.
- `inb`  in  WIDTH  multiplier. Captured on the accepting edge.
- `acc_en`  in  1  add `acc_in` to the product. Captured on the accepting edge.
- `acc_in`  in  2*WIDTH  addend. Captured on the accepting edge.
- `result`  out  2*WIDTH  low 2*WIDTH bits of the final sum.
- `carry`  out  1  bit 2*WIDTH of the final sum.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `ready_n`  out  1  low while `result` holds a valid, unsuperseded result.

## Operation
- NDIG = WIDTH/DIGIT iterations.
- **States:** IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(iteration count = NDIG-1)--> DONE.
  - DONE --start--> RUN.
  - DONE --!start--> IDLE.
- **Accepting edge** (start high in IDLE or DONE):
  - Capture `ina`, `inb`, `acc_en`, `acc_in`.
  - Load the accumulator with `acc_en ? acc_in : 0`.
  - Clear the iteration counter.
  - Set `busy=1` and `ready_n=1`.
- **RUN iteration i** (i = 0..NDIG-1):
  - Take digit d = `inb[i*DIGIT +: DIGIT]`, LSB digit first.
  - Update `acc += (ina*d) << (i*DIGIT)`.
- **Widths:**
  - Partial product: WIDTH+DIGIT bits.
  - Accumulator: 2*WIDTH+1 bits, no truncation.
  - `{carry, result}` equals `ina*inb + (acc_en ? acc_in : 0)` exactly.
  - `carry` is always 0 when `acc_en=0`.
- **Completion edge** (last iteration):
  - `result`/`carry` are updated.
  - `busy=0`, `done=1` for exactly one cycle, `ready_n=0`.
- `result`, `carry` and `ready_n=0` hold until the next accepting edge or reset.
- `start` while RUN is ignored; it is neither queued nor allowed to corrupt the operation.
- Operand inputs may change freely after the accepting edge.
- **`rst` at any time**, including mid-RUN:
  - State goes to IDLE.
  - Reset values: `result=0`, `carry=0`, `busy=0`, `done=0`, `ready_n=1`.
  - Any in-flight operation is discarded; no `done` is produced.

## Timing
- **Latency:** the accepting edge is edge k. `done=1` and `result` are valid after edge k+NDIG; `busy` is high from after edge k through edge k+NDIG-1.
  - WIDTH=64, DIGIT=4: 16 cycles.
  - WIDTH=64, DIGIT=1: 64 cycles.
- **Throughput:** one operation per NDIG+1 cycles back to back. `start` held high during the DONE cycle is accepted on that edge, giving a new operation with no idle cycle.
- `done` and `ready_n` are registered outputs, with no combinational path from inputs.
- Reset assertion acts asynchronously. Deassertion is assumed synchronised externally. The first `start` is sampled on the first edge after deassertion.

## Structure
- **Shared package `mul_pkg`:**
  - State enum (IDLE/RUN/DONE).
  - Function `ndig(WIDTH, DIGIT)`.
  - An elaboration-time check that WIDTH % DIGIT == 0.
- **Sub-module `mul_digit`:**
  - Combinational WIDTH x DIGIT partial-product generator.
  - Output is WIDTH+DIGIT bits.
  - Instantiated once.
- **Top level contains:**
  - FSM.
  - Iteration counter, `$clog2(NDIG)` bits, minimum 1.
  - Operand registers.
  - 2*WIDTH+1-bit accumulator and shifter.

## Test plan
All scenarios are checked against a behavioural model `{carry,result} = ina*inb + (acc_en?acc_in:0)`. Defaults are WIDTH=64, DIGIT=4 unless stated.

1. `ina=1`, `inb=1`, `acc_en=0` → `result=1`, `carry=0`; `done` pulses exactly 16 cycles after the accepting edge; `busy` is high for 16 cycles.
2. `ina=0x10`, `inb=0x100` → `result=0x1000`. Then `ina=0xed91f81fda13`, `inb=0xd91ae301dedd` → `result` matches the model.
3. `ina=inb=0xFFFF_FFFF_FFFF_FFFF`, `acc_en=1`, `acc_in` all ones → `result=0xFFFFFFFFFFFFFFFE_0000000000000000`, `carry=1`. The same operands with `acc_en=0` → `result=0xFFFFFFFFFFFFFFFE_0000000000000001`, `carry=0`.
4. `start` pulsed again 5 cycles into RUN, with operands changed at the same time → original result, and a single `done` at cycle 16.
5. `rst` asserted 8 cycles into RUN → all outputs take their reset values immediately; no `done` ever follows. A fresh `start` after release completes normally.
6. Back-to-back: `start` held high continuously for 3 operations → `done` pulses 17 cycles apart, each result is correct. Repeat with WIDTH=32, DIGIT=1: `0xf81fda13*0xe301dedd` matches the model after 32 cycles.
